// File: rtl/multinomial_dmas.sv
// Pixel-level DMAS beamformer core: per-channel signed sqrt, then
// y = ((sum sh)^2 - sum sh^2) / 2, shifted and saturated to 17 bits.
module multinomial_dmas #(
  parameter int unsigned CHANNELS     = 128,
  parameter int unsigned SQRT_LATENCY = 5,
  parameter int unsigned OUT_SHIFT    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] rfdata,
  output logic signed [16:0] bf_out
);

  localparam int unsigned L    = SQRT_LATENCY;
  localparam int unsigned CntW = $clog2(CHANNELS + L + 6);

  localparam logic [CntW-1:0] CapCnt      = CntW'(CHANNELS + 1);
  localparam logic [CntW-1:0] AccFirstCnt = CntW'(L + 1);
  localparam logic [CntW-1:0] AccLastCnt  = CntW'(CHANNELS + L + 2);
  localparam logic [CntW-1:0] SqCnt       = CntW'(CHANNELS + L + 3);
  localparam logic [CntW-1:0] FinCnt      = CntW'(CHANNELS + L + 4);

  // Iterations of the 8-step sqrt completed by the end of pipeline stage i.
  function automatic int unsigned it_end(int unsigned i);
    return (8 * i) / L;
  endfunction

  logic [CntW-1:0] cnt_q;
  logic [15:0]     s_in, mag_in;

  logic [15:0] x_q    [L+1];
  logic [11:0] rem_q  [L+1];
  logic [7:0]  root_q [L+1];
  logic        neg_q  [L+1];
  logic [15:0] x_c    [L+1];
  logic [11:0] rem_c  [L+1];
  logic [7:0]  root_c [L+1];

  logic signed [16:0] s_q, sh;
  logic [22:0]        q_q;
  logic [15:0]        rsq;
  logic signed [33:0] s_ext, p_q;
  logic signed [34:0] diff, y, z;
  logic signed [16:0] bf_d;
  logic               acc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q <= FinCnt) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Outside the capture window the pipeline is fed zeros.
  always_comb begin
    s_in   = (cnt_q <= CapCnt) ? rfdata : 16'd0;
    mag_in = s_in[15] ? (~s_in + 16'd1) : s_in;
  end

  always_comb begin
    logic [15:0] x;
    logic [11:0] rem;
    logic [7:0]  root;
    logic [11:0] trial;
    x = '0;
    rem = '0;
    root = '0;
    trial = '0;
    for (int unsigned i = 0; i <= L; i++) begin
      x_c[i]    = '0;
      rem_c[i]  = '0;
      root_c[i] = '0;
    end
    for (int unsigned i = 1; i <= L; i++) begin
      x    = x_q[i-1];
      rem  = rem_q[i-1];
      root = root_q[i-1];
      for (int unsigned k = 0; k < 8; k++) begin
        if (k >= it_end(i - 1) && k < it_end(i)) begin
          rem   = {rem[9:0], x[15:14]};
          x     = {x[13:0], 2'b00};
          trial = {2'b00, root, 2'b01};
          if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[6:0], 1'b1};
          end else begin
            root = {root[6:0], 1'b0};
          end
        end
      end
      x_c[i]    = x;
      rem_c[i]  = rem;
      root_c[i] = root;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= L; i++) begin
        x_q[i]    <= '0;
        rem_q[i]  <= '0;
        root_q[i] <= '0;
        neg_q[i]  <= 1'b0;
      end
    end else begin
      x_q[0]    <= mag_in;
      rem_q[0]  <= '0;
      root_q[0] <= '0;
      neg_q[0]  <= s_in[15];
      for (int unsigned i = 1; i <= L; i++) begin
        x_q[i]    <= x_c[i];
        rem_q[i]  <= rem_c[i];
        root_q[i] <= root_c[i];
        neg_q[i]  <= neg_q[i-1];
      end
    end
  end

  always_comb begin
    acc_en = (cnt_q >= AccFirstCnt) && (cnt_q <= AccLastCnt);
    sh     = neg_q[L] ? -$signed({9'd0, root_q[L]}) : $signed({9'd0, root_q[L]});
    rsq    = {8'd0, root_q[L]} * {8'd0, root_q[L]};
    s_ext  = {{17{s_q[16]}}, s_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      q_q <= '0;
      p_q <= '0;
    end else begin
      if (acc_en) begin
        s_q <= s_q + sh;
        q_q <= q_q + {7'd0, rsq};
      end
      if (cnt_q == SqCnt) begin
        p_q <= s_ext * s_ext;
      end
    end
  end

  // P - Q is always even, so the halving is exact; the output shift floors.
  always_comb begin
    diff = {p_q[33], p_q} - $signed({12'd0, q_q});
    y    = diff >>> 1;
    z    = y >>> OUT_SHIFT;
    if (z > 35'sd65535) begin
      bf_d = 17'sd65535;
    end else if (z < -35'sd65536) begin
      bf_d = -17'sd65536;
    end else begin
      bf_d = z[16:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bf_out <= '0;
    end else if (cnt_q == FinCnt) begin
      bf_out <= bf_d;
    end
  end

endmodule

// File: tb/tb_multinomial_dmas.sv
// Bench for multinomial_dmas: three parameterisations share one stimulus stream and are
// checked every cycle against an arithmetic model, plus literal end-of-frame values.
module tb_multinomial_dmas;

  logic               clk;
  logic               rst;
  logic signed [15:0] rfdata;
  logic signed [16:0] bf_main, bf_small, bf_sat;

  int n_tests = 0;
  int n_fail  = 0;
  int samp [256];
  int exp_main, exp_small, exp_sat;

  multinomial_dmas u_main (
    .clk    (clk),
    .rst    (rst),
    .rfdata (rfdata),
    .bf_out (bf_main)
  );

  multinomial_dmas #(
    .CHANNELS  (4),
    .OUT_SHIFT (0)
  ) u_small (
    .clk    (clk),
    .rst    (rst),
    .rfdata (rfdata),
    .bf_out (bf_small)
  );

  multinomial_dmas #(
    .OUT_SHIFT (0)
  ) u_sat (
    .clk    (clk),
    .rst    (rst),
    .rfdata (rfdata),
    .bf_out (bf_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  // DMAS by its direct definition: pairwise products of signed integer square roots.
  function automatic int model(input int ch, input int os);
    longint sh [256];
    longint y;
    for (int c = 0; c < ch; c++) begin
      int v, mag, r;
      v = samp[c];
      mag = (v < 0) ? -v : v;
      r = 0;
      while ((r + 1) * (r + 1) <= mag) r++;
      sh[c] = (v < 0) ? -r : r;
    end
    y = 0;
    for (int i = 0; i < ch; i++)
      for (int j = i + 1; j < ch; j++)
        y += sh[i] * sh[j];
    y = y >>> os;
    if (y > 65535) y = 65535;
    if (y < -65536) y = -65536;
    return int'(y);
  endfunction

  // Every cycle: outputs stay 0 until the final edge of each instance, then hold the model.
  int ed = 0;
  always @(posedge clk) begin
    logic rs;
    rs = rst;
    if (rs) ed = 0;
    else ed++;
    #1;
    check("main_cycle",  int'(bf_main),  (!rs && ed >= 138) ? exp_main  : 0);
    check("small_cycle", int'(bf_small), (!rs && ed >= 14)  ? exp_small : 0);
    check("sat_cycle",   int'(bf_sat),   (!rs && ed >= 138) ? exp_sat   : 0);
  end

  task automatic run_frame(input int n);
    @(negedge clk);
    rst = 1'b1;
    rfdata = '0;
    exp_main  = model(128, 12);
    exp_small = model(4, 0);
    exp_sat   = model(128, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < n; e++) begin
      if (e >= 2 && e < 130) rfdata = 16'(samp[e-2]);
      else rfdata = '0;
      @(negedge clk);
    end
  endtask

  task automatic fill(input int a, input int b);
    for (int c = 0; c < 256; c++) samp[c] = (c % 2 == 0) ? a : b;
  endtask

  initial begin
    rst = 1'b1;
    rfdata = '0;

    fill(0, 0);
    run_frame(150);
    check("zero_main", int'(bf_main), 0);
    check("zero_sat",  int'(bf_sat),  0);

    fill(0, 0);
    samp[0] = 4;
    samp[1] = 9;
    samp[2] = -16;
    samp[3] = 1;
    run_frame(150);
    check("small_lit", int'(bf_small), -13);

    fill(32767, 32767);
    run_frame(150);
    check("pos_main", int'(bf_main), 65010);
    check("pos_sat",  int'(bf_sat),  65535);

    fill(-32768, -32768);
    run_frame(150);
    check("neg_main", int'(bf_main), 65010);

    // Aborted frame: reset lands on edge 60, then a different frame runs clean.
    fill(32767, 32767);
    run_frame(60);
    fill(32767, -32768);
    run_frame(150);
    check("alt_main",  int'(bf_main),  -512);
    check("alt_sat",   int'(bf_sat),   -65536);
    check("alt_small", int'(bf_small), -65522);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
